// File: rtl/spi_flash_ce.sv
// Single-shot SPI flash chip-erase sequencer: WREN (0x06), a cs_n gap, then CE (0xC7), SPI mode 0.
// Optional registered busy output is enabled by defining SPI_CE_BUSY_EN.
module spi_flash_ce #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned GAP_CYC  = 8,
  parameter logic [7:0]  WREN_CMD = 8'h06,
  parameter logic [7:0]  CE_CMD   = 8'hC7
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic key_in,
  output logic cs_n,
  output logic sck,
  output logic sdi
`ifdef SPI_CE_BUSY_EN
  ,
  output logic busy
`endif
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WREN, S_GAP, S_CE} state_t;
  typedef enum logic [1:0] {P_SETUP, P_SHIFT, P_HOLD} phase_t;

  state_t           r_state, w_state_nxt;
  phase_t           r_phase, w_phase_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic             r_cs_n, r_sck, r_sdi;
  logic             w_cs_n_nxt, w_sck_nxt, w_sdi_nxt, w_framing;
  logic [7:0]       w_cmd;

  // Next-state sequencing: divider wraps drive setup -> 8 shift bits -> hold within a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_gap_nxt   = r_gap;
    case (r_state)
      S_IDLE: begin
        if (key_in) begin
          w_state_nxt = S_WREN;
          w_phase_nxt = P_SETUP;
          w_div_nxt   = '0;
          w_bit_nxt   = 3'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_CE;
          w_phase_nxt = P_SETUP;
          w_div_nxt   = '0;
          w_bit_nxt   = 3'd0;
        end else begin
          w_gap_nxt = r_gap + GAP_ONE;
        end
      end
      S_WREN, S_CE: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          case (r_phase)
            P_SETUP: begin
              w_phase_nxt = P_SHIFT;
              w_bit_nxt   = 3'd0;
            end
            P_SHIFT: begin
              if (r_bit == 3'd7) begin
                w_phase_nxt = P_HOLD;
              end else begin
                w_bit_nxt = r_bit + 3'd1;
              end
            end
            P_HOLD: begin
              w_phase_nxt = P_SETUP;
              w_gap_nxt   = '0;
              if (r_state == S_WREN) begin
                w_state_nxt = S_GAP;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so the registered pins line up with it.
  always_comb begin
    w_framing  = (w_state_nxt == S_WREN) || (w_state_nxt == S_CE);
    w_cmd      = (w_state_nxt == S_CE) ? CE_CMD : WREN_CMD;
    w_cs_n_nxt = !w_framing;
    w_sck_nxt  = 1'b0;
    w_sdi_nxt  = 1'b0;
    if (w_framing && (w_phase_nxt == P_SHIFT)) begin
      w_sck_nxt = (w_div_nxt >= DIV_HALF);
      w_sdi_nxt = w_cmd[3'd7 - w_bit_nxt];
    end else if (w_framing && (w_phase_nxt == P_HOLD)) begin
      w_sdi_nxt = w_cmd[0];
    end else begin
      w_sdi_nxt = 1'b0;
    end
  end

  // State, counters and registered pins.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= P_SETUP;
      r_div   <= '0;
      r_bit   <= 3'd0;
      r_gap   <= '0;
      r_cs_n  <= 1'b1;
      r_sck   <= 1'b0;
      r_sdi   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_gap   <= w_gap_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_sck   <= w_sck_nxt;
      r_sdi   <= w_sdi_nxt;
    end
  end

  assign cs_n = r_cs_n;
  assign sck  = r_sck;
  assign sdi  = r_sdi;

`ifdef SPI_CE_BUSY_EN
  logic r_busy;

  // Busy covers the whole sequence, falling with the final cs_n rise.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

  assign busy = r_busy;
`endif

endmodule

// File: tb/tb_spi_flash_ce.sv
// Self-checking bench for spi_flash_ce: constant checkpoint table, hand-written corner sequences,
// and random key_in traffic compared against an offset-based waveform model.
module tb_spi_flash_ce;

  localparam int CD    = 4;
  localparam int GAP   = 8;
  localparam int FRAME = 10 * CD;
  localparam int SEQ   = 2 * FRAME + GAP;

  logic sclk   = 1'b0;
  logic rst_n  = 1'b0;
  logic key_in = 1'b0;
  logic cs_n, sck, sdi;
`ifdef SPI_CE_BUSY_EN
  logic busy;
`endif

  spi_flash_ce #(.CLK_DIV(CD), .GAP_CYC(GAP), .WREN_CMD(8'h06), .CE_CMD(8'hC7)) dut (
    .sclk(sclk), .rst_n(rst_n), .key_in(key_in), .cs_n(cs_n), .sck(sck), .sdi(sdi)
`ifdef SPI_CE_BUSY_EN
    , .busy(busy)
`endif
  );

  always #10 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_t   = -1;  // model: cycles since the accept edge, -1 when idle

  typedef struct {int edges; logic [7:0] data; int low;} frame_t;
  frame_t     frames[$];
  int         mon_bits = 0;
  int         mon_low  = 0;
  int         idle_sck = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(posedge sck) begin
    if (cs_n) idle_sck++;
    else begin
      mon_byte = {mon_byte[6:0], sdi};
      mon_bits++;
    end
  end

  always @(posedge sclk) if (cs_n === 1'b0) mon_low++;

  always @(posedge cs_n) begin
    frames.push_back('{mon_bits, mon_byte, mon_low});
    mon_bits = 0;
    mon_low  = 0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] frame_out(input int u, input logic [7:0] cmd);
    int b, ph;
    if (u < CD) return 3'b000;
    if (u < 9 * CD) begin
      b  = (u - CD) / CD;
      ph = (u - CD) % CD;
      return {1'b0, (ph >= CD / 2), cmd[7 - b]};
    end
    return {1'b0, 1'b0, cmd[0]};
  endfunction

  function automatic logic [2:0] exp_out(input int t);
    logic [7:0] c;
    if (t < 0) return 3'b100;
    if (t < FRAME) begin
      c = 8'h06;
      return frame_out(t, c);
    end
    if (t < FRAME + GAP) return 3'b100;
    c = 8'hC7;
    return frame_out(t - FRAME - GAP, c);
  endfunction

  task automatic step(input logic k);
    key_in = k;
    @(posedge sclk);
    if (m_t >= 0) begin
      m_t++;
      if (m_t == SEQ) m_t = -1;
    end else if (k && rst_n) begin
      m_t = 0;
    end
    #1;
    key_in = 1'b0;
  endtask

  task automatic chk_cycle(input string nm);
    chk(nm, int'({cs_n, sck, sdi}), int'(exp_out(m_t)));
`ifdef SPI_CE_BUSY_EN
    chk({nm, "_busy"}, int'(busy), int'(m_t >= 0));
`endif
  endtask

  task automatic chk_frames(input string nm, input int first);
    chk({nm, "_n_frames"}, frames.size(), first + 2);
    if (frames.size() >= first + 2) begin
      chk({nm, "_f0_edges"}, frames[first].edges, 8);
      chk({nm, "_f0_data"}, int'(frames[first].data), 32'h06);
      chk({nm, "_f0_low"}, frames[first].low, FRAME);
      chk({nm, "_f1_edges"}, frames[first+1].edges, 8);
      chk({nm, "_f1_data"}, int'(frames[first+1].data), 32'hC7);
      chk({nm, "_f1_low"}, frames[first+1].low, FRAME);
    end
  endtask

  typedef struct {int off; logic [2:0] exp;} vec_t;
  vec_t vecs[$];

  initial begin
    int cur;
    int busy_hi;
    vecs = '{'{0, 3'b000}, '{3, 3'b000}, '{4, 3'b000}, '{6, 3'b010}, '{24, 3'b001},
             '{26, 3'b011}, '{28, 3'b001}, '{32, 3'b000}, '{36, 3'b000}, '{39, 3'b000},
             '{40, 3'b100}, '{47, 3'b100}, '{48, 3'b000}, '{52, 3'b001}, '{54, 3'b011},
             '{64, 3'b000}, '{84, 3'b001}, '{87, 3'b001}, '{88, 3'b100}};

    #45;
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_sck", int'(sck), 0);
    chk("rst_sdi", int'(sdi), 0);
    #55;
    rst_n = 1'b1;
    step(1'b0);
    chk_cycle("idle");
    frames.delete();
    idle_sck = 0;

    // Single request checked against the constant checkpoint table.
    step(1'b1);
    cur = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      while (cur < vecs[i].off) begin
        step(1'b0);
        cur++;
      end
      chk($sformatf("vec[%0d]@%0d", i, vecs[i].off), int'({cs_n, sck, sdi}), int'(vecs[i].exp));
    end
    chk_frames("single", 0);
    chk("idle_sck", idle_sck, 0);

    // Re-triggers during the gap and the CE shift are ignored.
    frames.delete();
    step(1'b1);
    chk_cycle("retrig");
    for (int i = 1; i < SEQ + 12; i++) begin
      step((i == 44) || (i == 60));
      chk_cycle("retrig");
    end
    chk_frames("retrig", 0);

    // Back-to-back: key on the cycle after CE's cs_n rises.
    frames.delete();
    step(1'b1);
    for (int i = 1; i <= SEQ; i++) begin
      step(1'b0);
      chk_cycle("b2b_a");
    end
    step(1'b1);
    chk("b2b_restart_cs_n", int'(cs_n), 0);
    for (int i = 1; i <= SEQ + 2; i++) begin
      step(1'b0);
      chk_cycle("b2b_b");
    end
    chk("b2b_n_frames", frames.size(), 4);

    // Asynchronous reset mid-shift, then a clean sequence.
    step(1'b1);
    for (int i = 0; i < 20; i++) step(1'b0);
    #5;
    rst_n = 1'b0;
    m_t   = -1;
    #1;
    chk("async_rst_pins", int'({cs_n, sck, sdi}), 3'b100);
    #5;
    rst_n = 1'b1;
    frames.delete();
    mon_bits = 0;
    mon_low  = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      chk_cycle("post_rst");
    end
    step(1'b1);
    busy_hi = 0;
`ifdef SPI_CE_BUSY_EN
    if (busy) busy_hi++;
`endif
    for (int i = 1; i <= SEQ + 2; i++) begin
      step(1'b0);
      chk_cycle("post_rst_seq");
`ifdef SPI_CE_BUSY_EN
      if (busy) busy_hi++;
`endif
    end
    chk_frames("post_rst", 0);
`ifdef SPI_CE_BUSY_EN
    chk("busy_cycles", busy_hi, SEQ);
`endif

    // Random key traffic against the model.
    idle_sck = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) == 0);
      chk_cycle("rand");
    end
    chk("rand_idle_sck", idle_sck, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
